ip_rx_cr_accum: RTL and testbench
=================================

Name: ip_rx_cr_accum

Overview:
- Downstream of the RX credit-decode stage. Consumes its single-cycle credit-release pulses: ph_cr, pd_cr with pd_num, nph_cr, npd_cr.
- Accumulates released credits per type and returns them to the PCIe core's credit-update interface in batches, one type per transfer.
- Batching limits update traffic. A shared timeout guarantees that small residues are still returned.

Parameters:
- CNT_W, 12: width of each pending counter and of ret_num.
- PH_THRESH, 4: pending PH count that makes PH eligible.
- PD_THRESH, 32: pending PD count (pd_num units) that makes PD eligible.
- NPH_THRESH, 2: pending NPH count that makes NPH eligible.
- NPD_THRESH, 2: pending NPD count that makes NPD eligible.
- TIMEOUT, 255: idle cycles before any nonzero counter becomes eligible. Legal range 1..255.

Ports:
- clk, input, 1: clock.
- rstn, input, 1: asynchronous active-low reset.
- ph_cr_in, input, 1: add 1 to PH pending.
- pd_cr_in, input, 1: add pd_num_in to PD pending.
- pd_num_in, input, 8: PD amount. Valid only with pd_cr_in. Zero-extended to CNT_W.
- nph_cr_in, input, 1: add 1 to NPH pending.
- npd_cr_in, input, 1: add 1 to NPD pending.
- flush, input, 1: level; while high, every nonzero counter is eligible.
- ret_vld, output, 1: credit return offered.
- ret_type, output, 2: 0=PH, 1=PD, 2=NPH, 3=NPD.
- ret_num, output, CNT_W: amount returned.
- ret_rdy, input, 1: core accepts the offer when ret_vld && ret_rdy.
- pend_any, output, 1: at least one pending counter is nonzero (registered counters).
- ovf_err, output, 1: sticky; a counter saturated.

Behaviour:
- Reset (async, rstn low):
  - All counters, timer, ret_vld, ret_type, ret_num, ovf_err and pend_any go to 0.
  - Round-robin pointer goes to 0 (PH). State goes to S_IDLE.
  - A reset mid-offer drops the offer and loses all pending credits.
- Accumulation, every cycle in any state:
  - cnt_T += increment_T.
  - Any number of the four inputs may pulse in the same cycle; each is applied independently.
  - Counters saturate at 2^CNT_W-1. An increment that would exceed this clamps the counter and sets ovf_err; ovf_err clears only on reset.
- Eligibility of type T:
  - cnt_T >= THRESH_T, or
  - cnt_T != 0 and (timer == TIMEOUT or flush).
  - Evaluated on registered counter values only.
- Timer:
  - Clears on reset, on an accepted return, and in any cycle where all counters are 0.
  - Otherwise increments by 1, saturating at TIMEOUT.
- FSM, two states:
  - S_IDLE: if any type is eligible, pick the first eligible type searching from the RR pointer upward (wrapping 3->0). Then:
    - ret_type <= T
    - ret_num <= cnt_T
    - cnt_T <= this cycle's increment_T (the snapshot is removed and a same-cycle arrival is kept)
    - ret_vld <= 1
    - next state S_OFFER
    
    If nothing is eligible, stay in S_IDLE.
  - S_OFFER:
    - ret_vld, ret_type and ret_num are held stable until ret_rdy.
    - On ret_vld && ret_rdy: ret_vld <= 0, RR pointer <= T+1 (mod 4), timer cleared, next state S_IDLE.
    - Counters keep accumulating meanwhile, including type T.
- Latency and throughput:
  - The pulse that makes a type eligible is registered at edge k; ret_vld is high after edge k+1.
  - Timeout case: a lone pulse captured at edge 0 gives ret_vld after edge TIMEOUT+1.
  - Minimum spacing between accepted returns is 2 cycles (one S_IDLE cycle is mandatory).
- ret_num is never 0 when ret_vld is high.
- pend_any = OR of the nonzero flags of all counters, registered each cycle.

Test Plan:
- PH threshold: 4 ph_cr_in pulses on consecutive cycles, ret_rdy=1 -> one offer of type 0, num 4, one cycle after the 4th pulse is registered; counter ends at 0.
- PD sum with collision: pd_cr_in num 20, then num 16 -> offer type 1, num 36. A further pd_cr_in num 5 in the load cycle -> counter ends at 5 and no second offer until timeout. Timeout then gives type 1, num 5.
- Timeout (TIMEOUT=16): one nph_cr_in at edge 0 -> ret_vld high after edge 17, type 2, num 1. With flush held high instead -> ret_vld high after edge 1.
- Backpressure: offer pending with ret_rdy=0 for 10 cycles while 3 more ph pulses arrive -> ret_type and ret_num stay constant. After ret_rdy, the next offer carries 3 once eligible.
- Round-robin: all four counters preloaded to their thresholds, pointer=0, ret_rdy=1 -> offer order PH, PD, NPH, NPD, each 2 cycles apart.
- Saturation and reset: with CNT_W=4, 16 ph pulses and ret_rdy=0 -> counter stops at 15 and ovf_err=1. Assert rstn low during S_OFFER -> all outputs 0 immediately; after release no offers and pend_any=0.

Source files
------------

// File: rtl/ip_rx_cr_accum.sv
// RX credit return accumulator: collects released PH/PD/NPH/NPD credits and
// hands them back to the core one type per transfer, batched by threshold or timeout.
module ip_rx_cr_accum #(
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned PH_THRESH  = 4,
    parameter int unsigned PD_THRESH  = 32,
    parameter int unsigned NPH_THRESH = 2,
    parameter int unsigned NPD_THRESH = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ph_cr_in,
    input  logic             pd_cr_in,
    input  logic [7:0]       pd_num_in,
    input  logic             nph_cr_in,
    input  logic             npd_cr_in,
    input  logic             flush,
    output logic             ret_vld,
    output logic [1:0]       ret_type,
    output logic [CNT_W-1:0] ret_num,
    input  logic             ret_rdy,
    output logic             pend_any,
    output logic             ovf_err
);

    localparam int unsigned NUM_T = 4;
    localparam int unsigned SUM_W = ((CNT_W > 8) ? CNT_W : 8) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});
    localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    function automatic int unsigned thresh_of(input logic [1:0] t);
        case (t)
            2'd0:    return PH_THRESH;
            2'd1:    return PD_THRESH;
            2'd2:    return NPH_THRESH;
            default: return NPD_THRESH;
        endcase
    endfunction

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt   [NUM_T];
    logic [CNT_W-1:0]   cnt_d [NUM_T];
    logic [SUM_W-1:0]   inc   [NUM_T];
    logic [SUM_W-1:0]   sum   [NUM_T];
    logic [NUM_T-1:0]   elig;
    logic [NUM_T-1:0]   nz;
    logic [7:0]         timer, timer_d;
    logic [1:0]         rr, rr_d, sel, idx;
    logic               any_elig, load, accept, ovf_d, pend_d;
    logic               ret_vld_d;
    logic [1:0]         ret_type_d;
    logic [CNT_W-1:0]   ret_num_d;

    // Per-type increments, PD amount zero-extended
    always_comb begin
        inc[0] = SUM_W'(ph_cr_in);
        inc[1] = pd_cr_in ? SUM_W'(pd_num_in) : '0;
        inc[2] = SUM_W'(nph_cr_in);
        inc[3] = SUM_W'(npd_cr_in);
    end

    // Eligibility from registered counters; nonzero guard keeps ret_num nonzero
    always_comb begin
        elig = '0;
        nz   = '0;
        for (int t = 0; t < NUM_T; t++) begin
            nz[t] = (cnt[t] != '0);
            if (nz[t] && ((32'(cnt[t]) >= thresh_of(2'(t))) || (timer == TIMEOUT_V) || flush))
                elig[t] = 1'b1;
        end
    end

    // First eligible type searching upward from the round-robin pointer
    always_comb begin
        sel      = rr;
        idx      = rr;
        any_elig = |elig;
        for (int i = NUM_T - 1; i >= 0; i--) begin
            idx = rr + 2'(i);
            if (elig[idx])
                sel = idx;
        end
    end

    // Next-state and offer control
    always_comb begin
        state_d    = state;
        ret_vld_d  = ret_vld;
        ret_type_d = ret_type;
        ret_num_d  = ret_num;
        rr_d       = rr;
        load       = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_elig) begin
                    load       = 1'b1;
                    ret_vld_d  = 1'b1;
                    ret_type_d = sel;
                    ret_num_d  = cnt[sel];
                    state_d    = S_OFFER;
                end
            end
            S_OFFER: begin
                if (ret_rdy) begin
                    accept    = 1'b1;
                    ret_vld_d = 1'b0;
                    rr_d      = ret_type + 2'd1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating accumulation; a loaded type keeps only this cycle's arrival
    always_comb begin
        ovf_d  = ovf_err;
        pend_d = 1'b0;
        for (int t = 0; t < NUM_T; t++) begin
            sum[t] = ((load && (sel == 2'(t))) ? '0 : SUM_W'(cnt[t])) + inc[t];
            if (sum[t] > CNT_MAX) begin
                cnt_d[t] = '1;
                ovf_d    = 1'b1;
            end else begin
                cnt_d[t] = CNT_W'(sum[t]);
            end
            pend_d = pend_d | (cnt_d[t] != '0);
        end
    end

    // Idle timer, saturating at TIMEOUT
    always_comb begin
        timer_d = timer;
        if (accept || (nz == '0))
            timer_d = '0;
        else if (timer != TIMEOUT_V)
            timer_d = timer + 8'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int t = 0; t < NUM_T; t++)
                cnt[t] <= '0;
            timer    <= '0;
            rr       <= '0;
            ret_vld  <= 1'b0;
            ret_type <= '0;
            ret_num  <= '0;
            pend_any <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            for (int t = 0; t < NUM_T; t++)
                cnt[t] <= cnt_d[t];
            timer    <= timer_d;
            rr       <= rr_d;
            ret_vld  <= ret_vld_d;
            ret_type <= ret_type_d;
            ret_num  <= ret_num_d;
            pend_any <= pend_d;
            ovf_err  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ip_rx_cr_accum.sv
// Directed bench for ip_rx_cr_accum: one instance with a short timeout,
// one with 4-bit counters for saturation and reset-during-offer.
module tb_ip_rx_cr_accum;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ph_cr_in, pd_cr_in, nph_cr_in, npd_cr_in, flush, ret_rdy;
    logic [7:0]  pd_num_in;

    logic        ret_vld_a, pend_any_a, ovf_err_a;
    logic [1:0]  ret_type_a;
    logic [11:0] ret_num_a;
    logic        ret_vld_b, pend_any_b, ovf_err_b;
    logic [1:0]  ret_type_b;
    logic [3:0]  ret_num_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ip_rx_cr_accum #(.TIMEOUT(16)) dut_a (
        .clk(clk), .rstn(rstn),
        .ph_cr_in(ph_cr_in), .pd_cr_in(pd_cr_in), .pd_num_in(pd_num_in),
        .nph_cr_in(nph_cr_in), .npd_cr_in(npd_cr_in), .flush(flush),
        .ret_vld(ret_vld_a), .ret_type(ret_type_a), .ret_num(ret_num_a),
        .ret_rdy(ret_rdy), .pend_any(pend_any_a), .ovf_err(ovf_err_a)
    );

    ip_rx_cr_accum #(.CNT_W(4), .PH_THRESH(16)) dut_b (
        .clk(clk), .rstn(rstn),
        .ph_cr_in(ph_cr_in), .pd_cr_in(pd_cr_in), .pd_num_in(pd_num_in),
        .nph_cr_in(nph_cr_in), .npd_cr_in(npd_cr_in), .flush(flush),
        .ret_vld(ret_vld_b), .ret_type(ret_type_b), .ret_num(ret_num_b),
        .ret_rdy(ret_rdy), .pend_any(pend_any_b), .ovf_err(ovf_err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] offa(input logic v, input logic [1:0] t, input logic [11:0] n);
        return 32'({v, t, n});
    endfunction

    function automatic logic [31:0] obsa();
        return 32'({ret_vld_a, ret_type_a, ret_num_a});
    endfunction

    initial begin
        logic [11:0] rr_num [4];
        rr_num[0] = 12'd4; rr_num[1] = 12'd32; rr_num[2] = 12'd2; rr_num[3] = 12'd2;

        rstn = 1'b0; ph_cr_in = 1'b0; pd_cr_in = 1'b0; pd_num_in = '0;
        nph_cr_in = 1'b0; npd_cr_in = 1'b0; flush = 1'b0; ret_rdy = 1'b1;
        tick(); tick();
        chk("reset_outputs", 32'({ret_vld_a, ret_type_a, ret_num_a, pend_any_a, ovf_err_a}), 32'd0);
        rstn = 1'b1;
        tick();

        // PH threshold: 4 pulses, offer one edge after the 4th is registered
        ph_cr_in = 1'b1;
        repeat (4) tick();
        ph_cr_in = 1'b0;
        chk("ph_before_offer", 32'(ret_vld_a), 32'd0);
        chk("ph_pend_any", 32'(pend_any_a), 32'd1);
        tick();
        chk("ph_offer", obsa(), offa(1'b1, 2'd0, 12'd4));
        chk("ph_cnt_cleared", 32'(pend_any_a), 32'd0);
        tick();
        chk("ph_accepted", 32'(ret_vld_a), 32'd0);
        tick();

        // PD sum 20+16, extra 5 arrives in the load cycle
        pd_cr_in = 1'b1; pd_num_in = 8'd20; tick();
        pd_num_in = 8'd16; tick();
        pd_num_in = 8'd5; tick();
        pd_cr_in = 1'b0; pd_num_in = '0;
        chk("pd_offer", obsa(), offa(1'b1, 2'd1, 12'd36));
        tick();
        chk("pd_accepted", 32'(ret_vld_a), 32'd0);
        chk("pd_residue_pending", 32'(pend_any_a), 32'd1);
        repeat (16) tick();
        chk("pd_no_early_offer", 32'(ret_vld_a), 32'd0);
        tick();
        chk("pd_timeout_offer", obsa(), offa(1'b1, 2'd1, 12'd5));
        tick();
        chk("pd_timeout_accepted", 32'({ret_vld_a, pend_any_a}), 32'd0);

        // Lone NPH pulse: offer after edge TIMEOUT+1
        nph_cr_in = 1'b1; tick();
        nph_cr_in = 1'b0;
        repeat (16) tick();
        chk("nph_to_not_yet", 32'(ret_vld_a), 32'd0);
        tick();
        chk("nph_to_offer", obsa(), offa(1'b1, 2'd2, 12'd1));
        tick();

        // Same pulse with flush held: offer after edge 1
        flush = 1'b1; nph_cr_in = 1'b1; tick();
        nph_cr_in = 1'b0;
        chk("nph_flush_edge0", 32'(ret_vld_a), 32'd0);
        tick();
        chk("nph_flush_offer", obsa(), offa(1'b1, 2'd2, 12'd1));
        flush = 1'b0;
        tick();

        // Backpressure: offer held stable while 3 more PH arrive
        ret_rdy = 1'b0;
        ph_cr_in = 1'b1;
        repeat (4) tick();
        ph_cr_in = 1'b0;
        tick();
        chk("bp_offer", obsa(), offa(1'b1, 2'd0, 12'd4));
        for (int i = 0; i < 10; i++) begin
            ph_cr_in = (i >= 2 && i < 5);
            tick();
            chk("bp_hold", obsa(), offa(1'b1, 2'd0, 12'd4));
        end
        ph_cr_in = 1'b0;
        ret_rdy = 1'b1;
        tick();
        chk("bp_accepted", 32'(ret_vld_a), 32'd0);
        flush = 1'b1;
        tick();
        chk("bp_next_offer", obsa(), offa(1'b1, 2'd0, 12'd3));
        flush = 1'b0;
        tick();

        // Return an NPD so the round-robin pointer wraps to PH
        npd_cr_in = 1'b1; flush = 1'b1; tick();
        npd_cr_in = 1'b0; tick();
        chk("npd_flush_offer", obsa(), offa(1'b1, 2'd3, 12'd1));
        flush = 1'b0;
        tick();

        // Round robin: all four types reach threshold on the same edge
        ph_cr_in = 1'b1; tick(); tick();
        pd_cr_in = 1'b1; pd_num_in = 8'd31; nph_cr_in = 1'b1; npd_cr_in = 1'b1; tick();
        chk("rr_not_yet", 32'(ret_vld_a), 32'd0);
        pd_num_in = 8'd1; tick();
        ph_cr_in = 1'b0; pd_cr_in = 1'b0; pd_num_in = '0; nph_cr_in = 1'b0; npd_cr_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_offer", obsa(), offa(1'b1, 2'(k), rr_num[k]));
            tick();
            chk("rr_gap", 32'(ret_vld_a), 32'd0);
        end
        chk("rr_drained", 32'({pend_any_a, ovf_err_a}), 32'd0);

        // Saturation on the 4-bit instance, then reset in the middle of an offer
        rstn = 1'b0; #3; rstn = 1'b1;
        ret_rdy = 1'b0;
        ph_cr_in = 1'b1;
        repeat (15) tick();
        chk("sat_no_ovf_at_15", 32'(ovf_err_b), 32'd0);
        tick();
        ph_cr_in = 1'b0;
        chk("sat_ovf_set", 32'(ovf_err_b), 32'd1);
        chk("sat_pend_any", 32'(pend_any_b), 32'd1);
        flush = 1'b1;
        tick();
        chk("sat_offer", 32'({ret_vld_b, ret_type_b, ret_num_b}), 32'({1'b1, 2'd0, 4'd15}));
        tick();
        chk("sat_ovf_sticky", 32'({ret_vld_b, ovf_err_b}), 32'({1'b1, 1'b1}));
        #2; rstn = 1'b0; #1;
        chk("rst_mid_offer_b", 32'({ret_vld_b, ret_type_b, ret_num_b, pend_any_b, ovf_err_b}), 32'd0);
        chk("rst_mid_offer_a", 32'({ret_vld_a, ret_type_a, ret_num_a, pend_any_a, ovf_err_a}), 32'd0);
        flush = 1'b0;
        #3; rstn = 1'b1;
        repeat (5) tick();
        chk("post_rst_quiet", 32'({ret_vld_b, pend_any_b, ovf_err_b}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
